// File: rtl/core_register_scoreboard_if.sv
// core_register_scoreboard_if
//   Bundles the issue/writeback/lookup signals of the register hazard scoreboard.
//   master : issue-stage side (drives requests, lookups and releases)
//   slave  : the scoreboard itself (returns tag, ack, hazards and status)
//   Signals:
//     iREFRESH                            flush all outstanding entries
//     iALLOC_VALID/SYSREG/REGISTER/PC     new outstanding write request
//     oALLOC_TAG, oALLOC_ACK              tag granted / request accepted
//     iWB_VALID, iWB_TAG                  writeback release by tag
//     iSRCn_VALID/SYSREG/REGISTER         operand lookup, n = 0,1
//     oSRCn_HAZARD                        lookup hit on an outstanding write
//     oFULL, oEMPTY, oCOUNT, oOLDEST_PC   occupancy status and oldest PC
interface core_register_scoreboard_if #(
    parameter int P_DEPTH = 4,
    parameter int P_TAG_W = 2,
    parameter int P_REG_W = 5,
    parameter int P_CNT_W = 3
);
    logic               iREFRESH;
    logic               iALLOC_VALID;
    logic               iALLOC_SYSREG;
    logic [P_REG_W-1:0] iALLOC_REGISTER;
    logic [31:0]        iALLOC_PC;
    logic [P_TAG_W-1:0] oALLOC_TAG;
    logic               oALLOC_ACK;
    logic               iWB_VALID;
    logic [P_TAG_W-1:0] iWB_TAG;
    logic               iSRC0_VALID;
    logic               iSRC0_SYSREG;
    logic [P_REG_W-1:0] iSRC0_REGISTER;
    logic               oSRC0_HAZARD;
    logic               iSRC1_VALID;
    logic               iSRC1_SYSREG;
    logic [P_REG_W-1:0] iSRC1_REGISTER;
    logic               oSRC1_HAZARD;
    logic               oFULL;
    logic               oEMPTY;
    logic [P_CNT_W-1:0] oCOUNT;
    logic [31:0]        oOLDEST_PC;

    modport master (
        output iREFRESH, iALLOC_VALID, iALLOC_SYSREG, iALLOC_REGISTER, iALLOC_PC,
               iWB_VALID, iWB_TAG,
               iSRC0_VALID, iSRC0_SYSREG, iSRC0_REGISTER,
               iSRC1_VALID, iSRC1_SYSREG, iSRC1_REGISTER,
        input  oALLOC_TAG, oALLOC_ACK, oSRC0_HAZARD, oSRC1_HAZARD,
               oFULL, oEMPTY, oCOUNT, oOLDEST_PC
    );

    modport slave (
        input  iREFRESH, iALLOC_VALID, iALLOC_SYSREG, iALLOC_REGISTER, iALLOC_PC,
               iWB_VALID, iWB_TAG,
               iSRC0_VALID, iSRC0_SYSREG, iSRC0_REGISTER,
               iSRC1_VALID, iSRC1_SYSREG, iSRC1_REGISTER,
        output oALLOC_TAG, oALLOC_ACK, oSRC0_HAZARD, oSRC1_HAZARD,
               oFULL, oEMPTY, oCOUNT, oOLDEST_PC
    );
endinterface

// File: rtl/core_register_scoreboard.sv
// core_register_scoreboard
//   Issue-stage hazard scoreboard. Tracks up to P_DEPTH outstanding destination
//   writes (GPR or SYSREG), one entry per write, addressed by an index tag.
//   Two source operands are looked up every cycle; writeback releases by tag;
//   iREFRESH flushes everything.
//   Ports:
//     iCLOCK   core clock, all state on rising edge
//     iRESET   asynchronous active-high reset
//     bus      core_register_scoreboard_if.slave (alloc / release / lookup / status)
//
//   Age tracking: each entry holds its rank among valid entries (0 = oldest).
//   A release decrements the rank of every younger valid entry, so ranks stay
//   dense and the oldest entry is always the one with rank 0.

// One scoreboard entry: state, age rank and the two operand comparators.
module core_register_scoreboard_entry #(
    parameter int P_TAG_W = 2,
    parameter int P_REG_W = 5
)(
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iRefresh,
    input  logic               iAlloc,        // this entry is allocated this cycle
    input  logic [P_TAG_W-1:0] iAllocAge,
    input  logic               iAllocSysreg,
    input  logic [P_REG_W-1:0] iAllocRegister,
    input  logic [31:0]        iAllocPc,
    input  logic               iRelease,      // this entry is released this cycle
    input  logic               iReleaseAny,   // some valid entry is released this cycle
    input  logic [P_TAG_W-1:0] iReleaseAge,   // rank of the entry being released
    input  logic               iSrc0Sysreg,
    input  logic [P_REG_W-1:0] iSrc0Register,
    input  logic               iSrc1Sysreg,
    input  logic [P_REG_W-1:0] iSrc1Register,
    output logic               oValid,
    output logic [P_TAG_W-1:0] oAge,
    output logic [31:0]        oPc,
    output logic               oMatch0,
    output logic               oMatch1
);
    logic               valid;
    logic               sysreg;
    logic [P_REG_W-1:0] register;
    logic [31:0]        pc;
    logic [P_TAG_W-1:0] age;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            valid    <= 1'b0;
            sysreg   <= 1'b0;
            register <= '0;
            pc       <= '0;
            age      <= '0;
        end else if (iRefresh) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (iAlloc) begin
            valid    <= 1'b1;
            sysreg   <= iAllocSysreg;
            register <= iAllocRegister;
            pc       <= iAllocPc;
            age      <= iAllocAge;
        end else if (iRelease) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (valid && iReleaseAny && (age > iReleaseAge)) begin
            // An older entry left: close the gap in the age order.
            age <= age - 1'b1;
        end
    end

    assign oValid  = valid;
    assign oAge    = age;
    assign oPc     = pc;
    assign oMatch0 = valid && (sysreg == iSrc0Sysreg) && (register == iSrc0Register);
    assign oMatch1 = valid && (sysreg == iSrc1Sysreg) && (register == iSrc1Register);
endmodule

module core_register_scoreboard #(
    parameter int P_DEPTH = 4,
    parameter int P_TAG_W = 2,
    parameter int P_REG_W = 5,
    parameter int P_CNT_W = 3
)(
    input  logic iCLOCK,
    input  logic iRESET,
    core_register_scoreboard_if.slave bus
);
    logic [P_DEPTH-1:0]              entryValid;
    logic [P_DEPTH-1:0][P_TAG_W-1:0] entryAge;
    logic [P_DEPTH-1:0][31:0]        entryPc;
    logic [P_DEPTH-1:0]              match0;
    logic [P_DEPTH-1:0]              match1;

    logic [P_CNT_W-1:0] count;
    logic [P_CNT_W-1:0] ageBase;
    logic [P_TAG_W-1:0] freeTag;
    logic [P_TAG_W-1:0] allocAge;
    logic [P_TAG_W-1:0] releaseAge;
    logic [31:0]        oldestPc;
    logic               full;
    logic               allocAck;
    logic               doAlloc;
    logic               relHit;
    logic               doRelease;

    assign full     = (count == P_CNT_W'(P_DEPTH));
    assign allocAck = bus.iALLOC_VALID && !full;

    // Flush drops any alloc/release of the same cycle; ack stays purely !full.
    assign doAlloc   = allocAck && !bus.iREFRESH;
    // Releasing an entry that is not valid changes nothing.
    assign relHit    = bus.iWB_VALID && entryValid[bus.iWB_TAG];
    assign doRelease = relHit && !bus.iREFRESH;

    // Lowest free entry from registered state, so a same-cycle release is never reused.
    always_comb begin
        freeTag = '0;
        for (int i = P_DEPTH - 1; i >= 0; i--) begin
            if (!entryValid[i]) freeTag = P_TAG_W'(i);
        end
    end

    assign releaseAge = entryAge[bus.iWB_TAG];

    // New entry is youngest: its rank is the number of entries still valid after this edge.
    assign ageBase  = count - P_CNT_W'(doRelease);
    assign allocAge = ageBase[P_TAG_W-1:0];

    for (genvar g = 0; g < P_DEPTH; g++) begin : gEntry
        core_register_scoreboard_entry #(
            .P_TAG_W (P_TAG_W),
            .P_REG_W (P_REG_W)
        ) uEntry (
            .iCLOCK         (iCLOCK),
            .iRESET         (iRESET),
            .iRefresh       (bus.iREFRESH),
            .iAlloc         (doAlloc && (freeTag == P_TAG_W'(g))),
            .iAllocAge      (allocAge),
            .iAllocSysreg   (bus.iALLOC_SYSREG),
            .iAllocRegister (bus.iALLOC_REGISTER),
            .iAllocPc       (bus.iALLOC_PC),
            .iRelease       (doRelease && (bus.iWB_TAG == P_TAG_W'(g))),
            .iReleaseAny    (doRelease),
            .iReleaseAge    (releaseAge),
            .iSrc0Sysreg    (bus.iSRC0_SYSREG),
            .iSrc0Register  (bus.iSRC0_REGISTER),
            .iSrc1Sysreg    (bus.iSRC1_SYSREG),
            .iSrc1Register  (bus.iSRC1_REGISTER),
            .oValid         (entryValid[g]),
            .oAge           (entryAge[g]),
            .oPc            (entryPc[g]),
            .oMatch0        (match0[g]),
            .oMatch1        (match1[g])
        );
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            count <= '0;
        end else if (bus.iREFRESH) begin
            count <= '0;
        end else if (doAlloc && !doRelease) begin
            count <= count + 1'b1;
        end else if (!doAlloc && doRelease) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        oldestPc = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (entryValid[i] && (entryAge[i] == '0)) oldestPc = entryPc[i];
        end
    end

    assign bus.oALLOC_TAG   = freeTag;
    assign bus.oALLOC_ACK   = allocAck;
    assign bus.oSRC0_HAZARD = bus.iSRC0_VALID && (|match0);
    assign bus.oSRC1_HAZARD = bus.iSRC1_VALID && (|match1);
    assign bus.oFULL        = full;
    assign bus.oEMPTY       = (count == '0);
    assign bus.oCOUNT       = count;
    assign bus.oOLDEST_PC   = oldestPc;
endmodule
